// File: rtl/scan_mux_nbit_pkg.sv
// Shared constants and helpers for the scanning channel multiplexer.
package scan_mux_nbit_pkg;

    localparam int N_DEFAULT   = 3;
    localparam int CH_DEFAULT  = 9;
    localparam int DIV_DEFAULT = 50000;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((v - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_mux_nbit_tick_gen.sv
// Prescaler: counts 0..DIV-1 while run is high and pulses tick on the last count.
module tick_gen
    import scan_mux_nbit_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    // A one-bit counter that never leaves 0 still works for DIV=1.
    localparam int CW = (DIV > 1) ? clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scan_mux_nbit.sv
// Scanning N-bit channel multiplexer: auto-steps through CH channels every DIV
// cycles or follows a manual select, with registered data, index and strobe outputs.
module scan_mux_nbit
    import scan_mux_nbit_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int CH  = CH_DEFAULT,
    parameter int DIV = DIV_DEFAULT,
    localparam int SW = clog2(CH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            mode,
    input  logic [SW-1:0]   sel_in,
    input  logic [CH*N-1:0] data_in,
    output logic [N-1:0]    f,
    output logic [SW-1:0]   sel_out,
    output logic [CH-1:0]   strobe,
    output logic            frame_done
);

    logic [SW-1:0] idx;
    logic [SW-1:0] sel_clamped;
    logic          tick;
    logic          last;
    logic          pre_rst_n;

    // Manual mode parks the prescaler at 0 so auto scanning resumes with a full step.
    assign pre_rst_n = reset_n && !(enable && mode);
    assign last      = (idx == SW'(CH - 1));

    always_comb begin
        sel_clamped = sel_in;
        if (int'(sel_in) >= CH) sel_clamped = SW'(CH - 1);
    end

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (pre_rst_n),
        .run     (enable && !mode),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx        <= '0;
            f          <= '0;
            sel_out    <= '0;
            strobe     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (enable) begin
                f       <= data_in[int'(idx)*N +: N];
                sel_out <= idx;
                strobe  <= CH'(1) << idx;
                if (mode) begin
                    idx <= sel_clamped;
                end else if (tick) begin
                    idx        <= last ? '0 : idx + SW'(1);
                    frame_done <= last;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_mux_nbit.sv
// Randomized scoreboard bench for scan_mux_nbit: DIV=4 and DIV=1 builds share stimulus.
module tb_scan_mux_nbit;

    localparam int N  = 3;
    localparam int CH = 9;
    localparam int SW = 4;

    typedef struct {
        int idx;
        int pre;
        int f;
        int sel;
        int strobe;
        int fd;
    } ref_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel_in = '0;
    logic [CH*N-1:0] din = '0;

    logic [N-1:0]  f4, f1;
    logic [SW-1:0] sel4, sel1;
    logic [CH-1:0] stb4, stb1;
    logic          fd4, fd1;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    ref_t m4, m1;
    ref_t q4[$];
    ref_t q1[$];

    always #5 clk = ~clk;

    scan_mux_nbit #(.N(N), .CH(CH), .DIV(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .sel_in(sel_in),
        .data_in(din), .f(f4), .sel_out(sel4), .strobe(stb4), .frame_done(fd4)
    );

    scan_mux_nbit #(.N(N), .CH(CH), .DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .sel_in(sel_in),
        .data_in(din), .f(f1), .sel_out(sel1), .strobe(stb1), .frame_done(fd1)
    );

    // Behavioural model: state after one clock edge given the inputs seen at that edge.
    function automatic ref_t ref_step(input ref_t s, input int div, input bit rst_n,
                                      input bit en, input bit md, input int sel,
                                      input logic [CH*N-1:0] d);
        ref_t r;
        r = s;
        if (!rst_n) begin
            r = '{default: 0};
            return r;
        end
        r.fd = 0;
        if (!en) return r;
        r.f      = int'(d >> (s.idx * N)) & ((1 << N) - 1);
        r.sel    = s.idx;
        r.strobe = 1 << s.idx;
        if (md) begin
            r.idx = (sel >= CH) ? CH - 1 : sel;
            r.pre = 0;
        end else if (s.pre == div - 1) begin
            r.pre = 0;
            r.fd  = (s.idx == CH - 1) ? 1 : 0;
            r.idx = (s.idx + 1) % CH;
        end else begin
            r.pre = s.pre + 1;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cycle, got, exp);
        end
    endtask

    initial begin
        m4 = '{default: 0};
        m1 = '{default: 0};
        forever begin
            @(posedge clk);
            cycle++;
            m4 = ref_step(m4, 4, reset_n, enable, mode, int'(sel_in), din);
            m1 = ref_step(m1, 1, reset_n, enable, mode, int'(sel_in), din);
            q4.push_back(m4);
            q1.push_back(m1);
        end
    end

    initial begin
        ref_t e;
        forever begin
            @(negedge clk);
            if (q4.size() == 0 || q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cycle=%0d got=0 expected=1", cycle);
            end else begin
                e = q4.pop_front();
                chk("div4.f",          32'(f4),   32'(e.f));
                chk("div4.sel_out",    32'(sel4), 32'(e.sel));
                chk("div4.strobe",     32'(stb4), 32'(e.strobe));
                chk("div4.frame_done", 32'(fd4),  32'(e.fd));
                e = q1.pop_front();
                chk("div1.f",          32'(f1),   32'(e.f));
                chk("div1.sel_out",    32'(sel1), 32'(e.sel));
                chk("div1.strobe",     32'(stb1), 32'(e.strobe));
                chk("div1.frame_done", 32'(fd1),  32'(e.fd));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Steer stimulus from the model's DIV=4 index; pre_t < 0 means any prescaler value.
    task automatic wait_idx(input int target, input int pre_t);
        int i;
        for (i = 0; i < 200; i++) begin
            if (m4.idx == target && (pre_t < 0 || m4.pre == pre_t)) break;
            cyc(1);
        end
        if (i == 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idx timeout got=%0d expected=%0d", m4.idx, target);
        end
    endtask

    initial begin
        logic [31:0] rnd;
        for (int k = 0; k < CH; k++) din[k*N +: N] = N'((k > 7) ? 7 : k);
        cyc(2);
        reset_n = 1'b1;
        enable  = 1'b1;
        cyc(80);

        // Freeze mid-step at index 3, then resume.
        wait_idx(3, 1);
        enable = 1'b0;
        cyc(10);
        enable = 1'b1;
        cyc(20);

        // Manual select, including out-of-range clamp.
        mode   = 1'b1;
        sel_in = SW'(5);
        cyc(3);
        sel_in = SW'(12);
        cyc(3);
        repeat (20) begin
            sel_in = SW'($urandom_range(0, 15));
            cyc(1);
        end
        mode = 1'b0;
        cyc(5);

        // Live data change on the selected channel.
        wait_idx(2, -1);
        din[2*N +: N] = 3'b101;
        cyc(2);
        din[2*N +: N] = 3'b010;

        // Reset mid-frame.
        wait_idx(7, -1);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(40);

        repeat (400) begin
            reset_n = ($urandom_range(0, 99) != 0);
            enable  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel_in  = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                rnd = $urandom;
                din = rnd[CH*N-1:0];
            end
            cyc(1);
        end
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
